serializer_1b_128to1: RTL and testbench

//  Parallel-to-serial controller that sequences a 1-bit 128:1 mux datapath.

---
 rtl/serializer_1b_128to1_pkg.sv | 12 +
 rtl/serializer_1b_128to1_if.sv | 25 ++
 rtl/serializer_1b_128to1_mux.sv | 14 +
 rtl/serializer_1b_128to1.sv | 84 ++++++++
 tb/tb_serializer_1b_128to1.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serializer_1b_128to1_pkg.sv
// Shared widths and state encoding for the 1-bit 128:1 serializer.
package serializer_1b_128to1_pkg;

  localparam int p_nbits = 128;
  localparam int p_sbits = $clog2(p_nbits);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/serializer_1b_128to1_if.sv
// Input word stream and output bit stream of the serializer.
// master = producer/consumer side, slave = serializer side.
interface serializer_1b_128to1_if;
  import serializer_1b_128to1_pkg::*;

  logic               in_val;
  logic               in_rdy;
  logic [p_nbits-1:0] in_msg;
  logic [p_sbits-1:0] in_len;
  logic               out_val;
  logic               out_rdy;
  logic               out_msg;
  logic               out_last;

  modport master (
    output in_val, in_msg, in_len, out_rdy,
    input  in_rdy, out_val, out_msg, out_last
  );

  modport slave (
    input  in_val, in_msg, in_len, out_rdy,
    output in_rdy, out_val, out_msg, out_last
  );

endinterface

// File: rtl/serializer_1b_128to1_mux.sv
// Combinational 1-bit N:1 mux selecting the bit currently on the serial link.
module mux_1b_nto1 #(
  parameter int p_nbits = 128,
  localparam int p_sbits = $clog2(p_nbits)
) (
  input  logic [p_nbits-1:0] in_,
  input  logic [p_sbits-1:0] sel,
  output logic               out
);

  // Pick one bit of the word by index.
  assign out = in_[sel];

endmodule

// File: rtl/serializer_1b_128to1.sv
// Parallel-to-serial controller: takes a word plus last-bit index and emits
// bits 0..len LSB first on a val/rdy stream, with back-to-back reload.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no word held; in_rdy=1, out_val=0
//  BUSY  | emitting word[cnt]; out_last when cnt==len; reload on last beat
module serializer_1b_128to1
  import serializer_1b_128to1_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  serializer_1b_128to1_if.slave   bus
);

  state_e             state;
  logic [p_nbits-1:0] word;
  logic [p_sbits-1:0] len;
  logic [p_sbits-1:0] cnt;

  logic busy;
  logic last;
  logic bit_sel;
  logic in_fire;
  logic out_fire;

  mux_1b_nto1 #(.p_nbits(p_nbits)) u_mux (
    .in_ (word),
    .sel (cnt),
    .out (bit_sel)
  );

  // Handshake decode; in_rdy looks at out_rdy so a new word can land on the
  // last beat without a bubble. in_val never feeds back into the ready/valid.
  assign busy         = (state == BUSY);
  assign last         = busy && (cnt == len);
  assign bus.out_val  = busy;
  assign bus.out_msg  = busy && bit_sel;
  assign bus.out_last = last;
  assign bus.in_rdy   = !busy || (last && bus.out_rdy);
  assign in_fire      = bus.in_val && bus.in_rdy;
  assign out_fire     = busy && bus.out_rdy;

  // Sequencer: load on accept, advance cnt on each output beat, reload or
  // return to IDLE after the last beat. cnt stops at len, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            word  <= bus.in_msg;
            len   <= bus.in_len;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (out_fire) begin
            if (!last) begin
              cnt <= cnt + 1'b1;
            end else if (in_fire) begin
              word <= bus.in_msg;
              len  <= bus.in_len;
              cnt  <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_1b_128to1.sv
// Directed and randomized checks for the 1-bit 128:1 serializer.
module tb_serializer_1b_128to1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass = 0;

  serializer_1b_128to1_if bus();

  serializer_1b_128to1 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] msg;
    logic [6:0]   len;
    logic [15:0]  exp_seq;   // expected bits, beat 0 in bit 0
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Present a word in IDLE, then follow it beat by beat with optional random
  // backpressure, comparing each fired bit against msg[idx].
  task automatic run_word(input logic [127:0] msg, input logic [6:0] len, input bit rand_rdy);
    int idx;
    int budget;
    bus.in_val = 1'b1;
    bus.in_msg = msg;
    bus.in_len = len;
    @(negedge clk);
    chk("rw_in_rdy", bus.in_rdy, 1);
    step();
    bus.in_val = 1'b0;
    idx = 0;
    budget = 0;
    while (idx <= int'(len) && budget < 2000) begin
      bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!bus.out_val) chk("rw_out_val", bus.out_val, 1);
      else if (bus.out_rdy) begin
        chk("rw_bit", bus.out_msg, msg[idx]);
        chk("rw_last", bus.out_last, (idx == int'(len)));
        idx++;
      end
      step();
      budget++;
    end
    if (budget >= 2000) chk("rw_timeout", 0, 1);
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("rw_idle_val", bus.out_val, 0);
  endtask

  initial begin
    bus.in_val  = 1'b0;
    bus.in_msg  = '0;
    bus.in_len  = '0;
    bus.out_rdy = 1'b1;

    vecs[0] = '{msg: 128'hA5, len: 7'd7, exp_seq: 16'h00A5};
    vecs[1] = '{msg: 128'h1, len: 7'd0, exp_seq: 16'h0001};
    vecs[2] = '{msg: 128'hFF0F, len: 7'd3, exp_seq: 16'h000F};
    vecs[3] = '{msg: {4'h8, 108'h0, 16'h1234}, len: 7'd15, exp_seq: 16'h1234};
    vecs[4] = '{msg: 128'h6, len: 7'd2, exp_seq: 16'h0006};

    // Reset state, then idle for 5 cycles with no change
    do_reset();
    @(negedge clk);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_msg", bus.out_msg, 0);
    chk("rst_out_last", bus.out_last, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("idle_out_val", bus.out_val, 0);
      chk("idle_in_rdy", bus.in_rdy, 1);
      chk("idle_out_msg", bus.out_msg, 0);
    end
    step();

    // Table-driven words with out_rdy held high
    for (int v = 0; v < 5; v++) begin
      bus.in_val = 1'b1;
      bus.in_msg = vecs[v].msg;
      bus.in_len = vecs[v].len;
      step();
      bus.in_val = 1'b0;
      for (int b = 0; b <= int'(vecs[v].len); b++) begin
        @(negedge clk);
        chk("tbl_out_val", bus.out_val, 1);
        chk("tbl_out_msg", bus.out_msg, vecs[v].exp_seq[b]);
        chk("tbl_out_last", bus.out_last, (b == int'(vecs[v].len)));
        step();
      end
      @(negedge clk);
      chk("tbl_end_val", bus.out_val, 0);
      chk("tbl_end_rdy", bus.in_rdy, 1);
      step();
    end

    // Full-width word: 127 zeros then a final 1
    run_word({1'b1, 127'h0}, 7'd127, 1'b0);
    step();

    // Backpressure on beat 1 of 128'h6 len 2 -> 0,1,1
    bus.in_val = 1'b1;
    bus.in_msg = 128'h6;
    bus.in_len = 7'd2;
    step();
    bus.in_val = 1'b0;
    @(negedge clk);
    chk("bp_beat0", bus.out_msg, 0);
    step();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_msg", bus.out_msg, 1);
      chk("bp_hold_last", bus.out_last, 0);
      chk("bp_hold_in_rdy", bus.in_rdy, 0);
      step();
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_beat1", bus.out_msg, 1);
    chk("bp_beat1_last", bus.out_last, 0);
    step();
    @(negedge clk);
    chk("bp_beat2", bus.out_msg, 1);
    chk("bp_beat2_last", bus.out_last, 1);
    step();
    @(negedge clk);
    chk("bp_done", bus.out_val, 0);
    step();

    // Back-to-back: word 5/len2, second word 2/len1 held on in_val throughout
    bus.in_val = 1'b1;
    bus.in_msg = 128'h5;
    bus.in_len = 7'd2;
    step();
    bus.in_msg = 128'h2;
    bus.in_len = 7'd1;
    @(negedge clk);
    chk("b2b_w1_b0", bus.out_msg, 1);
    chk("b2b_holdoff0", bus.in_rdy, 0);
    step();
    @(negedge clk);
    chk("b2b_w1_b1", bus.out_msg, 0);
    chk("b2b_holdoff1", bus.in_rdy, 0);
    step();
    @(negedge clk);
    chk("b2b_w1_b2", bus.out_msg, 1);
    chk("b2b_w1_last", bus.out_last, 1);
    chk("b2b_accept", bus.in_rdy, 1);
    step();
    bus.in_val = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap", bus.out_val, 1);
    chk("b2b_w2_b0", bus.out_msg, 0);
    chk("b2b_w2_b0_last", bus.out_last, 0);
    step();
    @(negedge clk);
    chk("b2b_w2_b1", bus.out_msg, 1);
    chk("b2b_w2_last", bus.out_last, 1);
    step();
    @(negedge clk);
    chk("b2b_done", bus.out_val, 0);
    step();

    // Reset on beat 3 of a len=7 word aborts it
    bus.in_val = 1'b1;
    bus.in_msg = 128'hA5;
    bus.in_len = 7'd7;
    step();
    bus.in_val = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    chk("abort_beat3_val", bus.out_val, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_val", bus.out_val, 0);
    chk("abort_in_rdy", bus.in_rdy, 1);
    chk("abort_out_last", bus.out_last, 0);
    step();
    step();
    @(negedge clk);
    chk("abort_stays_idle", bus.out_val, 0);
    step();
    run_word(128'h3, 7'd1, 1'b0);
    step();

    // Random words with random backpressure
    for (int w = 0; w < 20; w++) begin
      logic [127:0] m;
      logic [6:0]   l;
      m = {$urandom, $urandom, $urandom, $urandom};
      l = 7'($urandom_range(0, 127));
      run_word(m, l, 1'b1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
